// File: rtl/key_event_scheduler.sv
// ---------------------------------------------------------------------------
// key_event_scheduler
//
// Turns the filtered levels of a bank of debounced keys into discrete events
// (press, release, long-press). All keys share a single output channel with a
// valid/ready handshake, and a round-robin arbiter chooses between keys.
// Each key has one pending bit per event type. An event that fires again
// while its pending bit is still set is coalesced, and the key's sticky
// overrun flag is raised.
//
// Parameters
//   N_KEYS      number of debounced key inputs (1..16)
//   TICK_DIV    clock cycles per hold tick (>= 2)
//   LONG_TICKS  hold ticks before a long-press event (>= 1)
//
// Ports
//   i_CLOCK_SOURCE   system clock; all logic runs on the rising edge
//   i_RESET          synchronous, active-high reset
//   i_KEY_LEVEL      debounced key levels, 1 = pressed
//   i_EVENT_READY    consumer accepts the event while o_EVENT_VALID is high
//   i_OVERRUN_CLEAR  clears every o_OVERRUN bit (a same-cycle overrun wins)
//   o_EVENT_VALID    an event is presented on o_EVENT_KEY / o_EVENT_TYPE
//   o_EVENT_KEY      key index of the presented event
//   o_EVENT_TYPE     00 press, 01 release, 10 long-press
//   o_OVERRUN        sticky per-key flag: an event was coalesced
// ---------------------------------------------------------------------------
module key_event_scheduler #(
  parameter  int N_KEYS     = 4,
  parameter  int TICK_DIV   = 50000,
  parameter  int LONG_TICKS = 1000,
  localparam int KEY_W      = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              i_CLOCK_SOURCE,
  input  logic              i_RESET,
  input  logic [N_KEYS-1:0] i_KEY_LEVEL,
  input  logic              i_EVENT_READY,
  input  logic              i_OVERRUN_CLEAR,
  output logic              o_EVENT_VALID,
  output logic [KEY_W-1:0]  o_EVENT_KEY,
  output logic [1:0]        o_EVENT_TYPE,
  output logic [N_KEYS-1:0] o_OVERRUN
);

  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int HOLD_W = $clog2(LONG_TICKS + 1);

  typedef enum logic [1:0] {
    EV_PRESS   = 2'b00,
    EV_RELEASE = 2'b01,
    EV_LONG    = 2'b10
  } ev_type_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PRE_W-1:0]  pre_cnt;
  logic [N_KEYS-1:0] prev_level;
  logic [HOLD_W-1:0] hold_cnt [N_KEYS];
  logic [N_KEYS-1:0] pend_press;
  logic [N_KEYS-1:0] pend_long;
  logic [N_KEYS-1:0] pend_release;
  logic [KEY_W-1:0]  rr_ptr;

  // -------------------------------------------------------------------------
  // Event sources
  // -------------------------------------------------------------------------
  logic              tick;
  logic [N_KEYS-1:0] rise;
  logic [N_KEYS-1:0] fall;
  logic [N_KEYS-1:0] long_fire;

  assign tick = (pre_cnt == PRE_W'(TICK_DIV - 1));
  assign rise = i_KEY_LEVEL & ~prev_level;
  assign fall = ~i_KEY_LEVEL & prev_level;

  // The long event fires on the tick that takes the counter from LONG_TICKS-1
  // to LONG_TICKS. The counter then saturates, so a single press yields at
  // most one long event.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so that no path leaves it unassigned and infers a latch.
    long_fire = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      long_fire[k] = i_KEY_LEVEL[k] && tick &&
                     (hold_cnt[k] == HOLD_W'(LONG_TICKS - 1));
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin arbiter
  // -------------------------------------------------------------------------
  logic [N_KEYS-1:0] cand;
  logic              found;
  logic [KEY_W-1:0]  gnt_idx;
  logic              load;
  logic              do_grant;
  logic [N_KEYS-1:0] gnt_press;
  logic [N_KEYS-1:0] gnt_long;
  logic [N_KEYS-1:0] gnt_release;
  ev_type_t          gnt_type;
  logic [KEY_W-1:0]  next_ptr;

  assign cand = pend_press | pend_long | pend_release;

  // The output register can take a new event when it is empty, or when its
  // current event is being accepted. This allows one event per cycle.
  assign load     = !o_EVENT_VALID || i_EVENT_READY;
  assign do_grant = load && found;

  // Search starts at rr_ptr and wraps, so the first candidate at or after
  // the pointer wins.
  always_comb begin
    int idx;
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = 0; i < N_KEYS; i++) begin
      idx = (int'(rr_ptr) + i) % N_KEYS;
      if (!found && cand[idx]) begin
        found   = 1'b1;
        gnt_idx = KEY_W'(idx);
      end
    end
  end

  // Within one key, press goes ahead of long, and long goes ahead of release.
  // A press that is pending alongside its release is therefore always
  // reported first.
  always_comb begin
    gnt_press   = '0;
    gnt_long    = '0;
    gnt_release = '0;
    gnt_type    = EV_PRESS;
    if (do_grant) begin
      if (pend_press[gnt_idx]) begin
        gnt_press[gnt_idx] = 1'b1;
        gnt_type           = EV_PRESS;
      end else if (pend_long[gnt_idx]) begin
        gnt_long[gnt_idx] = 1'b1;
        gnt_type          = EV_LONG;
      end else begin
        gnt_release[gnt_idx] = 1'b1;
        gnt_type             = EV_RELEASE;
      end
    end
  end

  assign next_ptr = KEY_W'((int'(gnt_idx) + 1) % N_KEYS);

  // -------------------------------------------------------------------------
  // Overrun detection
  // -------------------------------------------------------------------------
  // An event that fires while its pending bit is already set is coalesced.
  // The exception is a bit that is granted in the same cycle: the bit then
  // takes the new occurrence cleanly, and nothing is lost.
  logic [N_KEYS-1:0] overrun_set;

  assign overrun_set = (rise      & pend_press   & ~gnt_press)   |
                       (long_fire & pend_long    & ~gnt_long)    |
                       (fall      & pend_release & ~gnt_release);

  // -------------------------------------------------------------------------
  // Sequential logic
  // -------------------------------------------------------------------------
  always_ff @(posedge i_CLOCK_SOURCE) begin
    // NOTE: state registers use non-blocking assignments, so every register
    // in this block samples the pre-edge values and the evaluation order
    // does not matter.
    if (i_RESET) begin
      pre_cnt       <= '0;
      // Capturing the live level here means that a key held through reset
      // does not report a press when reset is released.
      prev_level    <= i_KEY_LEVEL;
      pend_press    <= '0;
      pend_long     <= '0;
      pend_release  <= '0;
      rr_ptr        <= '0;
      o_EVENT_VALID <= 1'b0;
      o_EVENT_KEY   <= '0;
      o_EVENT_TYPE  <= EV_PRESS;
      o_OVERRUN     <= '0;
      // NOTE: the hold counters are a small array of flops, not a RAM, so
      // they can be reset in a loop like any other register.
      for (int k = 0; k < N_KEYS; k++) begin
        hold_cnt[k] <= '0;
      end
    end else begin
      pre_cnt    <= tick ? '0 : pre_cnt + PRE_W'(1);
      prev_level <= i_KEY_LEVEL;

      // A released key keeps its counter at zero. A pressed key counts ticks
      // up to LONG_TICKS and then holds.
      for (int k = 0; k < N_KEYS; k++) begin
        if (!i_KEY_LEVEL[k]) begin
          hold_cnt[k] <= '0;
        end else if (tick && (hold_cnt[k] != HOLD_W'(LONG_TICKS))) begin
          hold_cnt[k] <= hold_cnt[k] + HOLD_W'(1);
        end
      end

      pend_press   <= (pend_press   & ~gnt_press)   | rise;
      pend_long    <= (pend_long    & ~gnt_long)    | long_fire;
      pend_release <= (pend_release & ~gnt_release) | fall;

      // A clear takes effect in the same cycle as a new overrun, but the new
      // overrun wins and its bit reads 1.
      o_OVERRUN <= i_OVERRUN_CLEAR ? overrun_set : (o_OVERRUN | overrun_set);

      if (load) begin
        if (found) begin
          o_EVENT_VALID <= 1'b1;
          o_EVENT_KEY   <= gnt_idx;
          o_EVENT_TYPE  <= gnt_type;
          rr_ptr        <= next_ptr;
        end else begin
          o_EVENT_VALID <= 1'b0;
        end
      end
    end
  end

endmodule
